// File: rtl/step_counter_16.sv
// Four-bit up/down step counter driven by a prescaled tick and a push-button.
// Define STEP_COUNTER_DEBOUNCE_EN to filter the key through a DEBOUNCE-cycle debouncer.
module step_counter_16 #(
    parameter int unsigned PRESCALE = 50000000,
    parameter int unsigned DEBOUNCE = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       key_n,
    input  logic       load,
    input  logic [3:0] din,
    output logic [3:0] x,
    output logic       tick_o,
    output logic       wrap
);

    localparam logic [25:0] PRE_MAX = 26'(PRESCALE - 1);

    if (PRESCALE < 2 || DEBOUNCE < 1) begin : g_illegal_params
        $error("step_counter_16: PRESCALE must be >= 2 and DEBOUNCE >= 1");
    end

    logic       sync1, sync2;
    logic [1:0] fill_q;
    logic       key_lvl;
    logic       key_prev_q;
    logic       armed_q;
    logic       press;
    logic [25:0] pre_q;
    logic       step;
    logic [3:0] x_d;
    logic       wrap_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Marks when sync2 holds a key sample taken after reset rather than its reset value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q <= 2'b00;
        end else begin
            fill_q <= {fill_q[0], 1'b1};
        end
    end

`ifdef STEP_COUNTER_DEBOUNCE_EN
    localparam logic [19:0] DB_MAX = 20'(DEBOUNCE - 1);

    logic [19:0] db_cnt_q;
    logic        key_acc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt_q  <= '0;
            key_acc_q <= 1'b1;
        end else if (sync2 == key_acc_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_MAX) begin
            db_cnt_q  <= '0;
            key_acc_q <= sync2;
        end else begin
            db_cnt_q <= db_cnt_q + 20'd1;
        end
    end

    assign key_lvl = key_acc_q;
`else
    assign key_lvl = sync2;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_prev_q <= 1'b1;
        end else begin
            key_prev_q <= key_lvl;
        end
    end

    // A key held through reset must be seen released before any press may step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
        end else if (fill_q[1] && sync2 && key_lvl) begin
            armed_q <= 1'b1;
        end
    end

    assign press = armed_q & key_prev_q & ~key_lvl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (!en || pre_q == PRE_MAX) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 26'd1;
        end
    end

    assign tick_o = en & (pre_q == PRE_MAX);
    assign step   = press | tick_o;

    always_comb begin
        x_d    = x;
        wrap_d = 1'b0;
        if (load) begin
            x_d = din;
        end else if (step) begin
            x_d    = up ? x + 4'd1 : x - 4'd1;
            wrap_d = up ? (x == 4'd15) : (x == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x    <= '0;
            wrap <= 1'b0;
        end else begin
            x    <= x_d;
            wrap <= wrap_d;
        end
    end

endmodule

// File: tb/tb_step_counter_16.sv
// Scoreboard bench for step_counter_16: a driver predicts each cycle's outputs from a
// behavioural model and a negedge monitor compares them against the DUT.
module tb_step_counter_16;

    localparam int PRESCALE = 4;
    localparam int DEBOUNCE = 5;
`ifdef STEP_COUNTER_DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, en, up, key_n, load;
    logic [3:0] din;
    logic [3:0] x;
    logic       tick_o, wrap;

    step_counter_16 #(.PRESCALE(PRESCALE), .DEBOUNCE(DEBOUNCE)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .up     (up),
        .key_n  (key_n),
        .load   (load),
        .din    (din),
        .x      (x),
        .tick_o (tick_o),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        bit wrap;
        bit tick;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model state
    int m_x, m_pre, m_run;
    bit m_wrap, m_acc, m_acc_prev, m_armed;
    bit hist[$];

    task automatic model_reset();
        m_x = 0; m_pre = 0; m_run = 0;
        m_wrap = 0; m_acc = 1; m_acc_prev = 1; m_armed = 0;
        hist.delete();
    endtask

    // Applies one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit lvl, acc_before, press, tick;
        int j;
        if (!rst_n) begin
            model_reset();
            return;
        end
        j = hist.size();
        lvl = (j >= 2) ? hist[j-2] : 1'b1;
        acc_before = DB_ON ? m_acc : lvl;
        press = m_armed && m_acc_prev && !acc_before;
        tick = en && (m_pre == PRESCALE - 1);
        if (load) begin
            m_x = int'(din);
            m_wrap = 0;
        end else if (press || tick) begin
            m_wrap = up ? (m_x == 15) : (m_x == 0);
            m_x = up ? (m_x + 1) % 16 : (m_x + 15) % 16;
        end else begin
            m_wrap = 0;
        end
        m_pre = (!en || m_pre == PRESCALE - 1) ? 0 : m_pre + 1;
        if (j >= 2 && lvl && acc_before) m_armed = 1;
        m_acc_prev = acc_before;
        if (DB_ON) begin
            if (lvl != m_acc) begin
                m_run++;
                if (m_run == DEBOUNCE) begin
                    m_acc = lvl;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        hist.push_back(key_n);
    endtask

    task automatic drive(input bit r, input bit e, input bit u, input bit k, input bit l,
                         input logic [3:0] d);
        exp_t item;
        rst_n = r; en = e; up = u; key_n = k; load = l; din = d;
        item.x = m_x;
        item.wrap = m_wrap;
        item.tick = e && (m_pre == PRESCALE - 1);
        exp_q.push_back(item);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic repeat_drive(input int n, input bit r, input bit e, input bit u, input bit k,
                                input bit l, input logic [3:0] d);
        for (int i = 0; i < n; i++) drive(r, e, u, k, l, d);
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (x !== 4'(e.x) || wrap !== e.wrap || tick_o !== e.tick) begin
                errors++;
                $display("FAIL outputs cycle %0d: got x=%0d wrap=%b tick_o=%b, want x=%0d wrap=%b tick_o=%b",
                         cyc, x, wrap, tick_o, e.x, e.wrap, e.tick);
            end
        end
    end

    initial begin
        int  hold;
        bit  k, e, u, l;
        rst_n = 1'b0; en = 1'b0; up = 1'b1; key_n = 1'b1; load = 1'b0; din = 4'd0;
        @(posedge clk);
        model_reset();
        #1;

        // Reset state
        repeat_drive(2, 0, 0, 1, 1, 0, 4'd0);
        repeat_drive(4, 1, 0, 1, 1, 0, 4'd0);

        // Auto count up through a full wrap
        repeat_drive(70, 1, 1, 1, 1, 0, 4'd0);

        // Count down from 0, then load coinciding with ticks
        drive(1, 0, 0, 1, 1, 4'd0);
        repeat_drive(9, 1, 1, 0, 1, 0, 4'd0);
        repeat_drive(5, 1, 1, 0, 1, 1, 4'd9);
        repeat_drive(3, 1, 0, 0, 1, 0, 4'd0);

        // Short glitch, then long press, with prescaler idle
        repeat_drive(3, 1, 0, 1, 0, 0, 4'd0);
        repeat_drive(12, 1, 0, 1, 1, 0, 4'd0);
        repeat_drive(20, 1, 0, 1, 0, 0, 4'd0);
        repeat_drive(12, 1, 0, 1, 1, 0, 4'd0);

        // Press while ticks are running
        repeat_drive(12, 1, 1, 1, 0, 0, 4'd0);
        repeat_drive(12, 1, 1, 1, 1, 0, 4'd0);

        // Reset while key is held low
        drive(1, 0, 1, 1, 1, 4'd7);
        repeat_drive(12, 1, 0, 1, 0, 0, 4'd0);
        drive(0, 0, 1, 0, 0, 4'd0);
        repeat_drive(20, 1, 0, 1, 0, 0, 4'd0);
        repeat_drive(12, 1, 0, 1, 1, 0, 4'd0);
        repeat_drive(15, 1, 0, 1, 0, 0, 4'd0);
        repeat_drive(12, 1, 0, 1, 1, 0, 4'd0);

        // Randomised traffic
        k = 1'b1; hold = 5; u = 1'b1;
        for (int i = 0; i < 900; i++) begin
            if (hold == 0) begin
                k = ~k;
                hold = $urandom_range(1, 25);
            end
            hold--;
            e = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 19) == 0) u = ~u;
            l = ($urandom_range(0, 29) == 0);
            drive(($urandom_range(0, 199) != 0), e, u, k, l, 4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
